// File: rtl/sap_ctrl_seq_pkg.sv
// Shared types for the SAP-8 control sequencer: opcodes, bus sources, ALU functions, T-states.
// SAP_COND_JUMP_EN (optional define) enables the JC/JZ/JN conditional jumps in the decoder.
package sap_ctrl_seq_pkg;

    localparam int OPC_W = 4;
    localparam int T_W   = 3;

    localparam logic [T_W-1:0] T0 = 3'd0;
    localparam logic [T_W-1:0] T1 = 3'd1;
    localparam logic [T_W-1:0] T2 = 3'd2;
    localparam logic [T_W-1:0] T3 = 3'd3;
    localparam logic [T_W-1:0] T4 = 3'd4;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        BUS_NONE    = 3'd0,
        BUS_PC      = 3'd1,
        BUS_RAM     = 3'd2,
        BUS_IR_OPND = 3'd3,
        BUS_A       = 3'd4,
        BUS_ALU     = 3'd5
    } bus_src_e;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_AND = 4'h9,
        OP_OR  = 4'hA,
        OP_XOR = 4'hB,
        OP_JN  = 4'hC,
        OP_RSV = 4'hD,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef struct packed {
        bus_src_e bus_sel;
        logic     mar_ld;
        logic     ir_ld;
        logic     pc_inc;
        logic     pc_ld;
        logic     a_ld;
        logic     b_ld;
        logic     ram_we;
        logic     flags_ld;
        logic     out_ld;
        alu_op_e  alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '{
        bus_sel:  BUS_NONE,
        mar_ld:   1'b0,
        ir_ld:    1'b0,
        pc_inc:   1'b0,
        pc_ld:    1'b0,
        a_ld:     1'b0,
        b_ld:     1'b0,
        ram_we:   1'b0,
        flags_ld: 1'b0,
        out_ld:   1'b0,
        alu_op:   ALU_PASS
    };

    function automatic logic is_alu_instr(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic alu_op_e alu_op_for(input opcode_e op);
        alu_op_e res;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_SUB:  res = ALU_SUB;
            OP_AND:  res = ALU_AND;
            OP_OR:   res = ALU_OR;
            OP_XOR:  res = ALU_XOR;
            default: res = ALU_PASS;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sap_ctrl_seq_decode.sv
// Combinational microcode decoder: (t_state, opcode, flags) -> control word, end-of-instruction, halt request.
// SAP_COND_JUMP_EN selects real conditional jumps for opcodes 7/8/C; otherwise they decode as NOP.
module sap_ctrl_decode
    import sap_ctrl_seq_pkg::*;
(
    input  logic [T_W-1:0]   t_state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             flag_n,
    output ctrl_word_t       ctrl,
    output logic             last_t,
    output logic             halt_req
);

    opcode_e op;
    logic    cond_take;

    assign op = opcode_e'(opcode);

`ifdef SAP_COND_JUMP_EN
    always_comb begin
        cond_take = 1'b0;
        case (op)
            OP_JC:   cond_take = flag_c;
            OP_JZ:   cond_take = flag_z;
            OP_JN:   cond_take = flag_n;
            default: cond_take = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = flag_z ^ flag_c ^ flag_n;
    assign cond_take    = 1'b0;
`endif

    always_comb begin
        ctrl     = CTRL_IDLE;
        last_t   = 1'b0;
        halt_req = 1'b0;
        case (t_state)
            T0: begin
                ctrl.bus_sel = BUS_PC;
                ctrl.mar_ld  = 1'b1;
            end
            T1: begin
                ctrl.bus_sel = BUS_RAM;
                ctrl.ir_ld   = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            T2: begin
                case (op)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        ctrl.bus_sel = BUS_IR_OPND;
                        ctrl.mar_ld  = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl.bus_sel = BUS_IR_OPND;
                        ctrl.a_ld    = 1'b1;
                        last_t       = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.bus_sel = BUS_IR_OPND;
                        ctrl.pc_ld   = 1'b1;
                        last_t       = 1'b1;
                    end
                    OP_JC, OP_JZ, OP_JN: begin
`ifdef SAP_COND_JUMP_EN
                        ctrl.bus_sel = BUS_IR_OPND;
                        ctrl.pc_ld   = cond_take;
`endif
                        last_t       = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl.bus_sel = BUS_A;
                        ctrl.out_ld  = 1'b1;
                        last_t       = 1'b1;
                    end
                    OP_HLT: begin
                        halt_req = 1'b1;
                        last_t   = 1'b1;
                    end
                    default: begin
                        last_t = 1'b1;
                    end
                endcase
            end
            T3: begin
                case (op)
                    OP_LDA: begin
                        ctrl.bus_sel = BUS_RAM;
                        ctrl.a_ld    = 1'b1;
                        last_t       = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.bus_sel = BUS_A;
                        ctrl.ram_we  = 1'b1;
                        last_t       = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        ctrl.bus_sel = BUS_RAM;
                        ctrl.b_ld    = 1'b1;
                    end
                    default: begin
                        last_t = 1'b1;
                    end
                endcase
            end
            T4: begin
                // Result and flags land together so the next instruction's T2 sees fresh flags.
                if (is_alu_instr(op)) begin
                    ctrl.bus_sel  = BUS_ALU;
                    ctrl.a_ld     = 1'b1;
                    ctrl.flags_ld = 1'b1;
                    ctrl.alu_op   = alu_op_for(op);
                end
                last_t = 1'b1;
            end
            default: begin
                last_t = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP-8 control sequencer top: T-state counter and sticky HALT, gating the decoded control word.
// SAP_COND_JUMP_EN (optional define) is consumed by sap_ctrl_decode to enable JC/JZ/JN.
module sap_ctrl_seq
    import sap_ctrl_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [OPC_W-1:0] opcode,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             flag_n,
    output bus_src_e         bus_sel,
    output logic             mar_ld,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             a_ld,
    output logic             b_ld,
    output logic             ram_we,
    output logic             flags_ld,
    output logic             out_ld,
    output alu_op_e          alu_op,
    output logic             halted,
    output logic [T_W-1:0]   t_state
);

    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_state_e;

    seq_state_e       state_q, state_d;
    logic [T_W-1:0]   t_q, t_d;
    ctrl_word_t       dec_ctrl;
    ctrl_word_t       ctrl;
    logic             last_t;
    logic             halt_req;
    logic             active;

    sap_ctrl_decode u_decode (
        .t_state  (t_q),
        .opcode   (opcode),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_n   (flag_n),
        .ctrl     (dec_ctrl),
        .last_t   (last_t),
        .halt_req (halt_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_RUN;
            t_q     <= T0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    assign active = !rst && (state_q == SEQ_RUN) && en;

    // HALT parks the counter at T0 so a later reset needs no special clean-up.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        ctrl    = CTRL_IDLE;
        if ((state_q == SEQ_RUN) && en) begin
            if (halt_req) begin
                state_d = SEQ_HALT;
                t_d     = T0;
            end else if (last_t) begin
                t_d = T0;
            end else begin
                t_d = t_q + 3'd1;
            end
        end
        if (active) begin
            ctrl = dec_ctrl;
        end
    end

    assign bus_sel  = ctrl.bus_sel;
    assign mar_ld   = ctrl.mar_ld;
    assign ir_ld    = ctrl.ir_ld;
    assign pc_inc   = ctrl.pc_inc;
    assign pc_ld    = ctrl.pc_ld;
    assign a_ld     = ctrl.a_ld;
    assign b_ld     = ctrl.b_ld;
    assign ram_we   = ctrl.ram_we;
    assign flags_ld = ctrl.flags_ld;
    assign out_ld   = ctrl.out_ld;
    assign alu_op   = ctrl.alu_op;
    assign halted   = (state_q == SEQ_HALT) && !rst;
    assign t_state  = t_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Testbench for sap_ctrl_seq: directed cycle table, HLT/JZ sequences, and randomized run against an instruction-level model.
// Honours SAP_COND_JUMP_EN the same way as the design build.
module tb_sap_ctrl_seq;
    import sap_ctrl_seq_pkg::*;

    localparam logic [8:0] S_NONE = 9'b000000000;
    localparam logic [8:0] S_MAR  = 9'b100000000;
    localparam logic [8:0] S_IR   = 9'b010000000;
    localparam logic [8:0] S_PCI  = 9'b001000000;
    localparam logic [8:0] S_PCL  = 9'b000100000;
    localparam logic [8:0] S_A    = 9'b000010000;
    localparam logic [8:0] S_B    = 9'b000001000;
    localparam logic [8:0] S_WE   = 9'b000000100;
    localparam logic [8:0] S_FL   = 9'b000000010;
    localparam logic [8:0] S_OUT  = 9'b000000001;

    logic           clk = 1'b0;
    logic           rst, en, flag_z, flag_c, flag_n;
    logic [3:0]     opcode;
    bus_src_e       bus_sel;
    alu_op_e        alu_op;
    logic           mar_ld, ir_ld, pc_inc, pc_ld, a_ld, b_ld, ram_we, flags_ld, out_ld;
    logic           halted;
    logic [2:0]     t_state;

    int n_vec = 0;
    int n_mis = 0;

    sap_ctrl_seq dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .opcode   (opcode),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_n   (flag_n),
        .bus_sel  (bus_sel),
        .mar_ld   (mar_ld),
        .ir_ld    (ir_ld),
        .pc_inc   (pc_inc),
        .pc_ld    (pc_ld),
        .a_ld     (a_ld),
        .b_ld     (b_ld),
        .ram_we   (ram_we),
        .flags_ld (flags_ld),
        .out_ld   (out_ld),
        .alu_op   (alu_op),
        .halted   (halted),
        .t_state  (t_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] op;
        logic [2:0] flg;
        logic [2:0] bus;
        logic [8:0] strb;
        logic [2:0] alu;
        logic       hlt;
        logic       chk_t;
        logic [2:0] t;
    } vec_t;

    typedef struct {
        logic [2:0] bus;
        logic [8:0] strb;
        logic [2:0] alu;
        logic [2:0] t;
        logic       enter_halt;
    } step_t;

    step_t model_q[$];
    logic  model_halt;

    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] op, input logic [2:0] flg);
        rst    = r;
        en     = e;
        opcode = op;
        {flag_z, flag_c, flag_n} = flg;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] bus, input logic [8:0] strb,
                               input logic [2:0] alu, input logic hlt, input logic chk_t, input logic [2:0] t);
        logic [8:0] act_strb;
        logic       bad;
        act_strb = {mar_ld, ir_ld, pc_inc, pc_ld, a_ld, b_ld, ram_we, flags_ld, out_ld};
        bad = (bus_sel !== bus) || (act_strb !== strb) || (alu_op !== alu) || (halted !== hlt) ||
              (chk_t && (t_state !== t));
        n_vec++;
        if (bad) begin
            n_mis++;
            $display("[TB] FAIL %s: got bus=%0d strb=%b alu=%0d halted=%b t=%0d, want bus=%0d strb=%b alu=%0d halted=%b t=%0d%s",
                     name, bus_sel, act_strb, alu_op, halted, t_state, bus, strb, alu, hlt, t,
                     chk_t ? "" : "(t unchecked)");
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic r, input logic e, input logic [3:0] op, input logic [2:0] flg,
                                 input logic [2:0] bus, input logic [8:0] strb, input logic [2:0] alu,
                                 input logic hlt, input logic chk_t, input logic [2:0] t);
        vec_t v;
        v.rst = r; v.en = e; v.op = op; v.flg = flg;
        v.bus = bus; v.strb = strb; v.alu = alu; v.hlt = hlt; v.chk_t = chk_t; v.t = t;
        return v;
    endfunction

    function automatic step_t mks(input logic [2:0] bus, input logic [8:0] strb, input logic [2:0] alu,
                                  input logic [2:0] t, input logic h);
        step_t s;
        s.bus = bus; s.strb = strb; s.alu = alu; s.t = t; s.enter_halt = h;
        return s;
    endfunction

    // Whole-instruction expansion straight from the instruction table.
    task automatic buildInstr(input logic [3:0] op, input logic fz, input logic fc, input logic fn);
        logic [2:0] fn_alu;
        logic       take;
        model_q.push_back(mks(BUS_PC,  S_MAR,        ALU_PASS, 3'd0, 1'b0));
        model_q.push_back(mks(BUS_RAM, S_IR | S_PCI, ALU_PASS, 3'd1, 1'b0));
        case (op)
            4'h2: fn_alu = ALU_ADD;
            4'h3: fn_alu = ALU_SUB;
            4'h9: fn_alu = ALU_AND;
            4'hA: fn_alu = ALU_OR;
            4'hB: fn_alu = ALU_XOR;
            default: fn_alu = ALU_PASS;
        endcase
        take = (op == 4'h7) ? fc : (op == 4'h8) ? fz : fn;
        case (op)
            4'h1: begin
                model_q.push_back(mks(BUS_IR_OPND, S_MAR, ALU_PASS, 3'd2, 1'b0));
                model_q.push_back(mks(BUS_RAM,     S_A,   ALU_PASS, 3'd3, 1'b0));
            end
            4'h2, 4'h3, 4'h9, 4'hA, 4'hB: begin
                model_q.push_back(mks(BUS_IR_OPND, S_MAR,       ALU_PASS, 3'd2, 1'b0));
                model_q.push_back(mks(BUS_RAM,     S_B,         ALU_PASS, 3'd3, 1'b0));
                model_q.push_back(mks(BUS_ALU,     S_A | S_FL,  fn_alu,   3'd4, 1'b0));
            end
            4'h4: begin
                model_q.push_back(mks(BUS_IR_OPND, S_MAR, ALU_PASS, 3'd2, 1'b0));
                model_q.push_back(mks(BUS_A,       S_WE,  ALU_PASS, 3'd3, 1'b0));
            end
            4'h5: model_q.push_back(mks(BUS_IR_OPND, S_A,   ALU_PASS, 3'd2, 1'b0));
            4'h6: model_q.push_back(mks(BUS_IR_OPND, S_PCL, ALU_PASS, 3'd2, 1'b0));
            4'h7, 4'h8, 4'hC: begin
`ifdef SAP_COND_JUMP_EN
                model_q.push_back(mks(BUS_IR_OPND, take ? S_PCL : S_NONE, ALU_PASS, 3'd2, 1'b0));
`else
                model_q.push_back(mks(BUS_NONE, S_NONE, ALU_PASS, 3'd2, 1'b0));
`endif
            end
            4'hE: model_q.push_back(mks(BUS_A,    S_OUT,  ALU_PASS, 3'd2, 1'b0));
            4'hF: model_q.push_back(mks(BUS_NONE, S_NONE, ALU_PASS, 3'd2, 1'b1));
            default: model_q.push_back(mks(BUS_NONE, S_NONE, ALU_PASS, 3'd2, 1'b0));
        endcase
    endtask

    vec_t tbl[$];

    initial begin
        logic [2:0] jz_bus_t, jz_bus_nt;
        logic [8:0] jz_strb_t;
        applyStimulus(1'b1, 1'b0, 4'h0, 3'b000);

        // Cycle-by-cycle directed table: reset, ADD, LDI, STA, SUB, LDA with en stall, NOP, OUT, D, JMP, rst mid-instr, XOR.
        tbl.push_back(mkv(1,0,4'h0,0, BUS_NONE,    S_NONE,      ALU_PASS,0,0,0));
        tbl.push_back(mkv(1,1,4'h0,0, BUS_NONE,    S_NONE,      ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h2,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h2,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'h2,0, BUS_IR_OPND, S_MAR,       ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'h2,0, BUS_RAM,     S_B,         ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,1,4'h2,0, BUS_ALU,     S_A|S_FL,    ALU_ADD, 0,1,4));
        tbl.push_back(mkv(0,1,4'h5,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h5,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'h5,0, BUS_IR_OPND, S_A,         ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'h4,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h4,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'h4,0, BUS_IR_OPND, S_MAR,       ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'h4,0, BUS_A,       S_WE,        ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,1,4'h3,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h3,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'h3,0, BUS_IR_OPND, S_MAR,       ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'h3,0, BUS_RAM,     S_B,         ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,1,4'h3,0, BUS_ALU,     S_A|S_FL,    ALU_SUB, 0,1,4));
        tbl.push_back(mkv(0,1,4'h1,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h1,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'h1,0, BUS_IR_OPND, S_MAR,       ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,0,4'h1,0, BUS_NONE,    S_NONE,      ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,0,4'h1,0, BUS_NONE,    S_NONE,      ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,0,4'h1,0, BUS_NONE,    S_NONE,      ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,1,4'h1,0, BUS_RAM,     S_A,         ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,1,4'h0,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h0,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'h0,0, BUS_NONE,    S_NONE,      ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'hE,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'hE,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'hE,0, BUS_A,       S_OUT,       ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'hD,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'hD,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'hD,0, BUS_NONE,    S_NONE,      ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'h6,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h6,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'h6,0, BUS_IR_OPND, S_PCL,       ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'h9,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'h9,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'h9,0, BUS_IR_OPND, S_MAR,       ALU_PASS,0,1,2));
        tbl.push_back(mkv(1,1,4'h9,0, BUS_NONE,    S_NONE,      ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,1,4'hB,0, BUS_PC,      S_MAR,       ALU_PASS,0,1,0));
        tbl.push_back(mkv(0,1,4'hB,0, BUS_RAM,     S_IR|S_PCI,  ALU_PASS,0,1,1));
        tbl.push_back(mkv(0,1,4'hB,0, BUS_IR_OPND, S_MAR,       ALU_PASS,0,1,2));
        tbl.push_back(mkv(0,1,4'hB,0, BUS_RAM,     S_B,         ALU_PASS,0,1,3));
        tbl.push_back(mkv(0,1,4'hB,0, BUS_ALU,     S_A|S_FL,    ALU_XOR, 0,1,4));
        tbl.push_back(mkv(0,0,4'h0,0, BUS_NONE,    S_NONE,      ALU_PASS,0,1,0));

        stepCycle();
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].op, tbl[i].flg);
            @(negedge clk);
            checkOutput($sformatf("table[%0d]", i), tbl[i].bus, tbl[i].strb, tbl[i].alu,
                        tbl[i].hlt, tbl[i].chk_t, tbl[i].t);
            stepCycle();
        end

        // HLT: sticky across en toggling, cleared only by rst.
        applyStimulus(1'b1, 1'b0, 4'hF, 3'b000);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 4'hF, 3'b000);
        stepCycle();
        stepCycle();
        @(negedge clk);
        checkOutput("hlt_t2", BUS_NONE, S_NONE, ALU_PASS, 1'b0, 1'b1, 3'd2);
        stepCycle();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, i[0], 4'h5, 3'b111);
            @(negedge clk);
            checkOutput($sformatf("halted[%0d]", i), BUS_NONE, S_NONE, ALU_PASS, 1'b1, 1'b0, 3'd0);
            stepCycle();
        end
        applyStimulus(1'b1, 1'b1, 4'h5, 3'b000);
        @(negedge clk);
        checkOutput("hlt_rst", BUS_NONE, S_NONE, ALU_PASS, 1'b0, 1'b0, 3'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 4'h5, 3'b000);
        @(negedge clk);
        checkOutput("hlt_exit_t0", BUS_PC, S_MAR, ALU_PASS, 1'b0, 1'b1, 3'd0);
        stepCycle();
        stepCycle();
        stepCycle();

        // JZ taken then not taken.
`ifdef SAP_COND_JUMP_EN
        jz_bus_t = BUS_IR_OPND; jz_bus_nt = BUS_IR_OPND; jz_strb_t = S_PCL;
`else
        jz_bus_t = BUS_NONE;    jz_bus_nt = BUS_NONE;    jz_strb_t = S_NONE;
`endif
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 4'h8, (k == 0) ? 3'b100 : 3'b011);
            @(negedge clk);
            checkOutput($sformatf("jz%0d_t0", k), BUS_PC, S_MAR, ALU_PASS, 1'b0, 1'b1, 3'd0);
            stepCycle();
            stepCycle();
            @(negedge clk);
            checkOutput($sformatf("jz%0d_t2", k), (k == 0) ? jz_bus_t : jz_bus_nt,
                        (k == 0) ? jz_strb_t : S_NONE, ALU_PASS, 1'b0, 1'b1, 3'd2);
            stepCycle();
        end
        @(negedge clk);
        checkOutput("jz_return_t0", BUS_PC, S_MAR, ALU_PASS, 1'b0, 1'b1, 3'd0);
        stepCycle();

        // Randomized run against the instruction-level model.
        begin
            logic       r, e;
            logic [3:0] cur_op;
            logic [2:0] cur_flg;
            step_t      s;
            model_q.delete();
            model_halt = 1'b0;
            cur_op  = 4'h0;
            cur_flg = 3'b000;
            for (int i = 0; i < 3000; i++) begin
                r = (i == 0) || ($urandom_range(0, 49) == 0);
                e = ($urandom_range(0, 99) < 85);
                if (!r && !model_halt && model_q.size() == 0) begin
                    cur_op  = 4'($urandom_range(0, 15));
                    cur_flg = 3'($urandom_range(0, 7));
                    buildInstr(cur_op, cur_flg[2], cur_flg[1], cur_flg[0]);
                end
                applyStimulus(r, e, cur_op, cur_flg);
                @(negedge clk);
                if (r) begin
                    checkOutput($sformatf("rnd[%0d] rst", i), BUS_NONE, S_NONE, ALU_PASS, 1'b0, 1'b0, 3'd0);
                end else if (model_halt) begin
                    checkOutput($sformatf("rnd[%0d] halt", i), BUS_NONE, S_NONE, ALU_PASS, 1'b1, 1'b0, 3'd0);
                end else if (e) begin
                    checkOutput($sformatf("rnd[%0d] op%h", i, cur_op), model_q[0].bus, model_q[0].strb,
                                model_q[0].alu, 1'b0, 1'b1, model_q[0].t);
                end else begin
                    checkOutput($sformatf("rnd[%0d] stall", i), BUS_NONE, S_NONE, ALU_PASS, 1'b0, 1'b1,
                                model_q[0].t);
                end
                stepCycle();
                if (r) begin
                    model_q.delete();
                    model_halt = 1'b0;
                end else if (!model_halt && e) begin
                    s = model_q.pop_front();
                    if (s.enter_halt) model_halt = 1'b1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
